// File: rtl/mult_pkg.sv
// Shared definitions for the multiplier job sequencer.
// FSM encoding, default width and watchdog limit.
package mult_pkg;

    localparam int N_DEF = 16;
    localparam int TIMEOUT = N_DEF + 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2
    } seq_state_t;

    function automatic int timeout_of(input int n);
        return n + 4;
    endfunction

endpackage

// File: rtl/result_fifo2.sv
// Two-entry first-word-fall-through FIFO.
// Push while full is accepted only alongside a pop.
module result_fifo2 #(
    parameter int W = 32
) (
    input  logic         clock,
    input  logic         Reset,
    input  logic         push,
    input  logic [W-1:0] push_data,
    input  logic         pop,
    output logic [W-1:0] head,
    output logic         full,
    output logic         empty
);

    logic [W-1:0] mem [2];
    logic         rd_ptr;
    logic         wr_ptr;
    logic [1:0]   count;
    logic         do_push;
    logic         do_pop;

    assign full    = (count == 2'd2);
    assign empty   = (count == 2'd0);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign head    = mem[rd_ptr];

    // pointers and occupancy
    always_ff @(posedge clock) begin
        if (!Reset) begin
            rd_ptr <= 1'b0;
            wr_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (do_push) wr_ptr <= ~wr_ptr;
            if (do_pop)  rd_ptr <= ~rd_ptr;
            case ({do_push, do_pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

    // storage; contents are don't-care while empty
    always_ff @(posedge clock) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/mult_job_sequencer.sv
// Job front end for the shift-add multiplier.
// One job in flight, watchdog on Done, results via 2-entry FIFO.
module mult_job_sequencer
    import mult_pkg::*;
#(
    parameter int N    = N_DEF,
    parameter int TO_W = 6
) (
    input  logic           clock,
    input  logic           Reset,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [N-1:0]   in_mcand,
    input  logic [N-1:0]   in_mplier,
    output logic           mul_start,
    output logic [N-1:0]   mul_mcand,
    output logic [N-1:0]   mul_mplier,
    input  logic           mul_done,
    input  logic [2*N:0]   mul_result,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [2*N-1:0] out_product,
    output logic           err_timeout
);

    localparam logic [TO_W-1:0] TMO = TO_W'(timeout_of(N));

    seq_state_t      state;
    seq_state_t      state_nxt;
    logic [TO_W-1:0] wd;
    logic            rdy_c;
    logic            start_c;
    logic            push;
    logic            tmo_hit;
    logic            accept;
    logic            pop;
    logic            fifo_full;
    logic            fifo_empty;
    logic            unused_msb;

    // the carry-out bit of the multiplier never fits the product
    assign unused_msb = mul_result[2*N];

    assign in_ready  = rdy_c & Reset;
    assign mul_start = start_c & Reset;
    assign out_valid = !fifo_empty & Reset;
    assign accept    = in_valid & in_ready;
    assign pop       = out_valid & out_ready;

    // next state; Done counts only in WAIT, stale or spurious pulses drop
    always_comb begin
        state_nxt = state;
        rdy_c     = 1'b0;
        start_c   = 1'b0;
        push      = 1'b0;
        tmo_hit   = 1'b0;
        unique case (state)
            IDLE: begin
                rdy_c = !fifo_full;
                if (in_valid && !fifo_full) state_nxt = ISSUE;
            end
            ISSUE: begin
                start_c   = 1'b1;
                state_nxt = WAIT;
            end
            WAIT: begin
                if (mul_done) begin
                    push      = 1'b1;
                    state_nxt = IDLE;
                end else if (wd == TMO) begin
                    tmo_hit   = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // state register
    always_ff @(posedge clock) begin
        if (!Reset) state <= IDLE;
        else        state <= state_nxt;
    end

    // watchdog counts cycles spent in WAIT
    always_ff @(posedge clock) begin
        if (!Reset)             wd <= '0;
        else if (state != WAIT) wd <= '0;
        else                    wd <= wd + 1'b1;
    end

    // sticky timeout flag
    always_ff @(posedge clock) begin
        if (!Reset)       err_timeout <= 1'b0;
        else if (tmo_hit) err_timeout <= 1'b1;
    end

    // operands held for the multiplier until the next accept
    always_ff @(posedge clock) begin
        if (!Reset) begin
            mul_mcand  <= '0;
            mul_mplier <= '0;
        end else if (accept) begin
            mul_mcand  <= in_mcand;
            mul_mplier <= in_mplier;
        end
    end

    result_fifo2 #(.W(2*N)) u_fifo (
        .clock     (clock),
        .Reset     (Reset),
        .push      (push),
        .push_data (mul_result[2*N-1:0]),
        .pop       (pop),
        .head      (out_product),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

endmodule

// File: tb/tb_mult_job_sequencer.sv
// Bench for mult_job_sequencer with a behavioural multiplier stub.
// Vector table, hand-written corner sequences and a random run.
module tb_mult_job_sequencer;

    localparam int N = 16;
    localparam int LAT = N + 3;

    logic          clock = 1'b0;
    logic          Reset;
    logic          in_valid;
    logic          in_ready;
    logic [15:0]   in_mcand;
    logic [15:0]   in_mplier;
    logic          mul_start;
    logic [15:0]   mul_mcand;
    logic [15:0]   mul_mplier;
    logic          mul_done;
    logic [32:0]   mul_result;
    logic          out_valid;
    logic          out_ready;
    logic [31:0]   out_product;
    logic          err_timeout;

    logic          stub_en;
    logic          force_done;
    logic          busy;
    logic [5:0]    scnt;
    logic [31:0]   sprod;
    logic          stub_done;

    int total = 0;
    int bad = 0;

    always #5 clock = ~clock;

    mult_job_sequencer #(.N(N), .TO_W(6)) dut (
        .clock       (clock),
        .Reset       (Reset),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_mcand    (in_mcand),
        .in_mplier   (in_mplier),
        .mul_start   (mul_start),
        .mul_mcand   (mul_mcand),
        .mul_mplier  (mul_mplier),
        .mul_done    (mul_done),
        .mul_result  (mul_result),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_product (out_product),
        .err_timeout (err_timeout)
    );

    // multiplier stub: Done N+1 cycles after the Start cycle
    always @(posedge clock) begin
        if (!Reset) begin
            busy <= 1'b0;
            scnt <= 6'd0;
        end else if (mul_start && stub_en) begin
            busy  <= 1'b1;
            scnt  <= 6'd0;
            sprod <= 32'(mul_mcand) * 32'(mul_mplier);
        end else if (busy) begin
            if (scnt == 6'(N)) busy <= 1'b0;
            scnt <= scnt + 6'd1;
        end
    end

    assign stub_done  = busy && (scnt == 6'(N));
    assign mul_done   = stub_done | force_done;
    assign mul_result = stub_done ? {1'b1, sprod} : 33'h1_5A5A_A5A5;

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clock);
        Reset = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b0;
        force_done = 1'b0;
        stub_en = 1'b1;
        @(negedge clock);
        @(negedge clock);
        Reset = 1'b1;
    endtask

    task automatic do_job(input logic [15:0] a, input logic [15:0] b,
                          input logic [31:0] exp, input bit stale,
                          input string tag);
        int lat;
        int starts;
        logic [31:0] prod;
        @(negedge clock);
        in_valid = 1'b1;
        in_mcand = a;
        in_mplier = b;
        #1;
        chk({tag, " ready"}, in_ready, 1);
        @(negedge clock);
        in_valid = 1'b0;
        lat = 0;
        starts = 0;
        prod = '0;
        for (int c = 1; c <= 40; c++) begin
            force_done = stale && (c == 1);
            #1;
            if (mul_start) starts++;
            if (out_valid) begin
                lat = c;
                prod = out_product;
                break;
            end
            @(negedge clock);
        end
        force_done = 1'b0;
        chk({tag, " latency"}, lat, LAT);
        chk({tag, " product"}, prod, exp);
        chk({tag, " starts"}, starts, 1);
        chk({tag, " held op"}, mul_mcand, a);
        out_ready = 1'b1;
        @(negedge clock);
        out_ready = 1'b0;
        #1;
        chk({tag, " drained"}, out_valid, 0);
    endtask

    task automatic offer(input logic [15:0] a, input logic [15:0] b,
                         input string tag);
        bit ok;
        ok = 1'b0;
        @(negedge clock);
        in_valid = 1'b1;
        in_mcand = a;
        in_mplier = b;
        for (int c = 0; c < 100; c++) begin
            #1;
            if (in_ready) begin
                ok = 1'b1;
                break;
            end
            @(negedge clock);
        end
        @(negedge clock);
        in_valid = 1'b0;
        chk({tag, " accepted"}, ok, 1);
    endtask

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic [31:0] p;
    } vec_t;

    vec_t vecs[6];

    initial begin
        #1000000;
        $display("FAIL global time limit reached");
        $fatal(1, "time limit");
    end

    initial begin
        logic [31:0] got[$];
        logic [31:0] q[$];
        bit accepted;
        int hi;
        int seen;
        bit pend;
        int due;
        logic [31:0] pend_p;
        bit exp_rdy;
        bit exp_val;

        vecs[0] = '{16'd3, 16'd5, 32'd15};
        vecs[1] = '{16'hFFFF, 16'hFFFF, 32'hFFFE_0001};
        vecs[2] = '{16'h0000, 16'h1234, 32'h0000_0000};
        vecs[3] = '{16'h8000, 16'h0002, 32'h0001_0000};
        vecs[4] = '{16'hFFFF, 16'h0001, 32'h0000_FFFF};
        vecs[5] = '{16'h00FF, 16'h00FF, 32'h0000_FE01};

        in_mcand = '0;
        in_mplier = '0;
        Reset = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b0;
        force_done = 1'b0;
        stub_en = 1'b1;
        repeat (2) @(negedge clock);
        #1;
        chk("rst in_ready", in_ready, 0);
        chk("rst out_valid", out_valid, 0);
        chk("rst mul_start", mul_start, 0);
        chk("rst err", err_timeout, 0);
        chk("rst mcand", mul_mcand, 0);
        chk("rst mplier", mul_mplier, 0);
        @(negedge clock);
        Reset = 1'b1;

        for (int i = 0; i < 6; i++)
            do_job(vecs[i].a, vecs[i].b, vecs[i].p, 1'b0,
                   $sformatf("vec%0d", i));

        // spurious Done in IDLE
        @(negedge clock);
        force_done = 1'b1;
        @(negedge clock);
        force_done = 1'b0;
        seen = 0;
        for (int c = 0; c < 4; c++) begin
            #1;
            if (out_valid) seen++;
            @(negedge clock);
        end
        chk("idle done push", seen, 0);

        // stale-high Done during ISSUE
        do_job(16'd7, 16'd9, 32'd63, 1'b1, "stale");

        // backpressure
        offer(16'h11, 16'h22, "bp A");
        offer(16'h33, 16'h44, "bp B");
        @(negedge clock);
        in_valid = 1'b1;
        in_mcand = 16'h55;
        in_mplier = 16'h66;
        hi = 0;
        for (int c = 0; c < 50; c++) begin
            #1;
            if (in_ready) hi++;
            @(negedge clock);
        end
        #1;
        chk("bp blocked", hi, 0);
        chk("bp full valid", out_valid, 1);
        chk("bp head", out_product, 32'h242);
        accepted = in_ready;
        got.delete();
        for (int c = 0; c < 100 && got.size() < 3; c++) begin
            @(negedge clock);
            in_valid = !accepted;
            out_ready = 1'b1;
            #1;
            if (in_valid && in_ready) accepted = 1'b1;
            if (out_valid) got.push_back(out_product);
        end
        @(negedge clock);
        out_ready = 1'b0;
        in_valid = 1'b0;
        chk("bp count", got.size(), 3);
        if (got.size() == 3) begin
            chk("bp order0", got[0], 32'h242);
            chk("bp order1", got[1], 32'hD8C);
            chk("bp order2", got[2], 32'h21DE);
        end

        // timeout: stub never answers
        stub_en = 1'b0;
        @(negedge clock);
        in_valid = 1'b1;
        in_mcand = 16'd4;
        in_mplier = 16'd4;
        #1;
        chk("to ready", in_ready, 1);
        @(negedge clock);
        in_valid = 1'b0;
        seen = 0;
        for (int c = 1; c <= N + 7; c++) begin
            #1;
            if (out_valid) seen++;
            if (c == N + 6) chk("to err early", err_timeout, 0);
            if (c == N + 7) begin
                chk("to err set", err_timeout, 1);
                chk("to idle", in_ready, 1);
            end
            if (c < N + 7) @(negedge clock);
        end
        chk("to no push", seen, 0);
        stub_en = 1'b1;
        do_job(16'd100, 16'd200, 32'd20000, 1'b0, "post to");
        chk("to sticky", err_timeout, 1);

        // reset in the middle of WAIT
        @(negedge clock);
        in_valid = 1'b1;
        in_mcand = 16'h1111;
        in_mplier = 16'd2;
        @(negedge clock);
        in_valid = 1'b0;
        for (int c = 1; c < 10; c++) @(negedge clock);
        Reset = 1'b0;
        @(negedge clock);
        Reset = 1'b1;
        #1;
        chk("mid idle", in_ready, 1);
        chk("mid out_valid", out_valid, 0);
        chk("mid err", err_timeout, 0);
        chk("mid mcand", mul_mcand, 0);
        @(negedge clock);
        force_done = 1'b1;
        @(negedge clock);
        force_done = 1'b0;
        seen = 0;
        for (int c = 0; c < 25; c++) begin
            #1;
            if (out_valid) seen++;
            @(negedge clock);
        end
        chk("mid late done", seen, 0);

        // random traffic against a latency/occupancy model
        do_reset();
        q.delete();
        pend = 1'b0;
        due = 0;
        pend_p = '0;
        for (int cyc = 0; cyc < 1500; cyc++) begin
            @(negedge clock);
            if (pend && cyc == due) begin
                q.push_back(pend_p);
                pend = 1'b0;
            end
            in_valid = 1'($urandom_range(0, 1));
            in_mcand = 16'($urandom);
            in_mplier = 16'($urandom);
            out_ready = ($urandom_range(0, 3) != 0);
            #1;
            exp_rdy = !pend && (q.size() < 2);
            exp_val = (q.size() > 0);
            chk("rnd ready", in_ready, exp_rdy);
            chk("rnd valid", out_valid, exp_val);
            if (exp_val && out_valid)
                chk("rnd product", out_product, q[0]);
            if (exp_val && out_ready) void'(q.pop_front());
            if (exp_rdy && in_valid) begin
                pend = 1'b1;
                due = cyc + LAT;
                pend_p = 32'(in_mcand) * 32'(in_mplier);
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
